useq: RTL and testbench
=======================

Name: useq

Overview:
- Parametrised microsequencer. Next generation of the micro-address / next-state logic that drives the control store in the LC-3 Patt CPU.
- Holds the current micro-address register and computes the next micro-address from the microinstruction's IRD, COND and J fields.
- Adds beyond the existing sequencing: a configurable condition table width, a microsubroutine call/return stack, a global stall, and sticky error flags.
- Sits between the control-store ROM (fed by uaddr) and the datapath status signals.

Parameters:
- UADDR_W, 6: micro-address width; control store depth is 2^UADDR_W.
- OPC_W, 4: opcode width used by IRD dispatch; must be < UADDR_W.
- COND_W, 3: COND field width.
- STACK_DEPTH, 4: microcall return-stack entries, >= 1.
- RESET_UADDR, 18: micro-address loaded on reset (fetch state).
- WDOG_LIMIT, 255: watchdog threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- ird  in  1  IRD field: dispatch on opcode.
- cond  in  COND_W  COND field.
- j  in  UADDR_W  J field, base next address.
- call  in  1  push return address, then branch.
- ret  in  1  pop return address as next.
- stall  in  1  freeze all state this cycle.
- opcode  in  OPC_W  IR[15:12].
- mem_rdy  in  1  memory ready (R).
- ben  in  1  branch-enable latch.
- ir11  in  1  IR[11], addressing mode.
- psr15  in  1  privilege bit.
- int_pend  in  1  interrupt pending.
- uaddr  out  UADDR_W  current micro-address, registered.
- next_uaddr  out  UADDR_W  combinational address to be loaded at the next edge, ignoring rst.
- sp_depth  out  clog2(STACK_DEPTH+1)  stack occupancy.
- stack_ovf  out  1  sticky: push attempted when full.
- stack_unf  out  1  sticky: pop attempted when empty.
- seq_err  out  1  sticky: call and ret asserted together.
- wdog_trip  out  1  one-cycle pulse; tied 0 without the optional feature.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - uaddr=RESET_UADDR, stack emptied, sp_depth=0.
  - stack_ovf, stack_unf, seq_err and wdog_trip cleared.
  - rst overrides every other input.
- Condition branch address (cj), computed from j:
  - cond=0: j.
  - cond=1: j|(mem_rdy<<1).
  - cond=2: j|(ben<<2).
  - cond=3: j|ir11.
  - cond=4: j|(psr15<<3).
  - cond=5: j|(int_pend<<4).
  - Other codes: j.
  - OR'd bits beyond UADDR_W are dropped.
- next_uaddr priority, highest first:
  1. stall=1: uaddr (hold).
  2. ret=1: stack top, or RESET_UADDR if the stack is empty.
  3. ird=1: zero-extended opcode ({0, opcode}).
  4. Otherwise: cj.
- Stack behaviour:
  - call=1 (and ret=0, stall=0): push uaddr+1, modulo 2^UADDR_W, and take the ird/cj path.
  - Push when full: the push is dropped, stack_ovf is set, and the branch is still taken.
  - Pop when empty: stack_unf is set and next_uaddr=RESET_UADDR.
- call and ret together (not stalled):
  - ret wins and call is ignored (no push).
  - seq_err is set.
- stall=1:
  - No push, pop or flag update.
  - Watchdog counter frozen.
- Timing:
  - uaddr updates one cycle after inputs are sampled.
  - Memory waits are expressed as cond=1 with j pointing at the current state; the sequencer self-loops until mem_rdy=1.
- Error flags are sticky until rst.

Optional Feature:
- Macro USEQ_WATCHDOG_EN.
- When defined:
  - A counter increments each non-stalled cycle where next_uaddr==uaddr, and clears on any change of address.
  - When the counter reaches WDOG_LIMIT, the next edge forces uaddr=RESET_UADDR, empties the stack, pulses wdog_trip for 1 cycle, and clears the counter.
  - The watchdog has priority just below rst.
- When undefined:
  - No counter is built.
  - wdog_trip is constant 0.
  - WDOG_LIMIT is unused.

Test Plan:
- Reset: rst=1 for 1 edge, then ird=0, cond=0, j=0x05 → uaddr=18 after reset, 0x05 at the next edge; sp_depth=0 and all flags 0.
- Dispatch and branches:
  - ird=1, opcode=0xA → uaddr=0x0A.
  - cond=2, j=0x00, ben=1 → 0x04; ben=0 → 0x00.
  - cond=5, j=0x31, int_pend=1 → 0x31 (bit already set).
  - cond=3, j=0x14, ir11=1 → 0x15.
- Memory wait: uaddr=0x21, cond=1, j=0x21, mem_rdy=0 for 3 cycles then 1 → uaddr holds at 0x21 for 3 edges, then goes to 0x23.
- Call/return:
  - From uaddr=0x10, call with j=0x30 → uaddr=0x30, sp_depth=1.
  - ret → uaddr=0x11, sp_depth=0.
  - With STACK_DEPTH=4, make 5 nested calls → stack_ovf=1, sp_depth=4, branch still taken.
- Error cases:
  - ret on empty stack → uaddr=18, stack_unf=1.
  - call+ret in the same cycle → seq_err=1, pop only.
  - stall=1 during a call → no change in uaddr or sp_depth.
- Watchdog (USEQ_WATCHDOG_EN, WDOG_LIMIT=8): self-loop cond=1, mem_rdy=0 → wdog_trip pulses after 8 looping cycles and uaddr=18. Without the macro → loop persists and wdog_trip stays 0.

Source files
------------

// File: rtl/useq.sv
// rtl/useq.sv - parametrised microsequencer with microcall stack and sticky error flags
//
// Purpose: holds the current micro-address that feeds the control store. It
//   computes the next micro-address from the IRD, COND and J fields, and keeps
//   a return stack for microsubroutines.
// Optional feature: define USEQ_WATCHDOG_EN to build the self-loop watchdog.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ird, cond, j    microinstruction sequencing fields
//   call, ret       push return address and branch / pop return address
//   stall           freeze all sequencer state for this cycle
//   opcode          IR[15:12] for IRD dispatch
//   mem_rdy, ben, ir11, psr15, int_pend   datapath status inputs
//   uaddr           registered current micro-address
//   next_uaddr      address loaded at the next edge (rst not applied)
//   sp_depth        return-stack occupancy
//   stack_ovf, stack_unf, seq_err   sticky error flags
//   wdog_trip       one-cycle watchdog pulse (0 when the watchdog is not built)
module useq #(
  parameter int UADDR_W     = 6,
  parameter int OPC_W       = 4,
  parameter int COND_W      = 3,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_UADDR = 18,
  parameter int WDOG_LIMIT  = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ird,
  input  logic [COND_W-1:0]                  cond,
  input  logic [UADDR_W-1:0]                 j,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               stall,
  input  logic [OPC_W-1:0]                   opcode,
  input  logic                               mem_rdy,
  input  logic                               ben,
  input  logic                               ir11,
  input  logic                               psr15,
  input  logic                               int_pend,
  output logic [UADDR_W-1:0]                 uaddr,
  output logic [UADDR_W-1:0]                 next_uaddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_depth,
  output logic                               stack_ovf,
  output logic                               stack_unf,
  output logic                               seq_err,
  output logic                               wdog_trip
);

  localparam int SP_W = $clog2(STACK_DEPTH+1);
  localparam logic [UADDR_W-1:0] RST_A = UADDR_W'(RESET_UADDR);
  localparam logic [UADDR_W-1:0] ONE_A = UADDR_W'(1);

  // Stack is a shift register with the top of stack always in entry 0,
  // so no pointer-indexed access is needed.
  logic [UADDR_W-1:0] stk [STACK_DEPTH];
  logic [UADDR_W-1:0] cj;
  logic [UADDR_W-1:0] seq_nx;
  logic [31:0]        cond_x;
  logic               empty, full;
  logic               do_pop, pop_unf, do_call, do_push, push_ovf, both;
  logic               wdog_hit;

  assign empty = (sp_depth == '0);
  assign full  = (sp_depth == SP_W'(STACK_DEPTH));

  assign do_pop   = !stall && ret && !empty;
  assign pop_unf  = !stall && ret && empty;
  assign do_call  = !stall && call && !ret;
  assign do_push  = do_call && !full;
  assign push_ovf = do_call && full;
  assign both     = !stall && call && ret;

  assign cond_x = 32'(cond);

  // Status bits are ORed in at fixed positions; shifting within UADDR_W
  // drops any bit that lands beyond the address width.
  always_comb begin
    cj = j;
    case (cond_x)
      32'd1:   cj = j | (UADDR_W'(mem_rdy)  << 1);
      32'd2:   cj = j | (UADDR_W'(ben)      << 2);
      32'd3:   cj = j |  UADDR_W'(ir11);
      32'd4:   cj = j | (UADDR_W'(psr15)    << 3);
      32'd5:   cj = j | (UADDR_W'(int_pend) << 4);
      default: cj = j;
    endcase
  end

  always_comb begin
    seq_nx = cj;
    if (stall)
      seq_nx = uaddr;
    else if (ret)
      seq_nx = empty ? RST_A : stk[0];
    else if (ird)
      seq_nx = {{(UADDR_W-OPC_W){1'b0}}, opcode};
  end

  assign next_uaddr = wdog_hit ? RST_A : seq_nx;

  always_ff @(posedge clk) begin
    if (rst)
      uaddr <= RST_A;
    else
      uaddr <= next_uaddr;
  end

  always_ff @(posedge clk) begin
    if (rst || wdog_hit) begin
      sp_depth <= '0;
    end else if (do_pop) begin
      for (int i = 0; i < STACK_DEPTH-1; i++)
        stk[i] <= stk[i+1];
      sp_depth <= sp_depth - SP_W'(1);
    end else if (do_push) begin
      for (int i = STACK_DEPTH-1; i > 0; i--)
        stk[i] <= stk[i-1];
      stk[0]   <= uaddr + ONE_A;
      sp_depth <= sp_depth + SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      if (push_ovf) stack_ovf <= 1'b1;
      if (pop_unf)  stack_unf <= 1'b1;
      if (both)     seq_err   <= 1'b1;
    end
  end

`ifdef USEQ_WATCHDOG_EN
  localparam int WC_W = $clog2(WDOG_LIMIT+1);
  logic [WC_W-1:0] wcnt;

  assign wdog_hit = (wcnt == WC_W'(WDOG_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      wdog_trip <= 1'b0;
    end else if (wdog_hit) begin
      wcnt      <= '0;
      wdog_trip <= 1'b1;
    end else begin
      wdog_trip <= 1'b0;
      if (!stall)
        wcnt <= (seq_nx == uaddr) ? wcnt + WC_W'(1) : '0;
    end
  end
`else
  assign wdog_hit  = 1'b0;
  assign wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_useq.sv
// tb/tb_useq.sv - self-checking bench for the useq microsequencer
module tb_useq;

  logic       clk = 1'b0;
  logic       rst, ird, call, ret, stall;
  logic [2:0] cond;
  logic [5:0] j;
  logic [3:0] opcode;
  logic       mem_rdy, ben, ir11, psr15, int_pend;
  logic [5:0] uaddr, next_uaddr;
  logic [2:0] sp_depth;
  logic       stack_ovf, stack_unf, seq_err, wdog_trip;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  useq #(.WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .ird(ird), .cond(cond), .j(j), .call(call),
    .ret(ret), .stall(stall), .opcode(opcode), .mem_rdy(mem_rdy),
    .ben(ben), .ir11(ir11), .psr15(psr15), .int_pend(int_pend),
    .uaddr(uaddr), .next_uaddr(next_uaddr), .sp_depth(sp_depth),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .seq_err(seq_err),
    .wdog_trip(wdog_trip)
  );

  typedef struct {
    logic       ird;
    logic [2:0] cond;
    logic [5:0] j;
    logic [3:0] opcode;
    logic       mem_rdy, ben, ir11, psr15, int_pend;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle();
    rst = 0; ird = 0; call = 0; ret = 0; stall = 0; cond = 0; j = 0;
    opcode = 0; mem_rdy = 0; ben = 0; ir11 = 0; psr15 = 0; int_pend = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic go_to(input logic [5:0] a);
    idle();
    j = a;
    step();
  endtask

  initial begin
    bit saw;
    vecs[0]  = '{1'b1, 3'd0, 6'h00, 4'hA, 0, 0, 0, 0, 0, 6'h0A};
    vecs[1]  = '{1'b0, 3'd2, 6'h00, 4'h0, 0, 1, 0, 0, 0, 6'h04};
    vecs[2]  = '{1'b0, 3'd2, 6'h00, 4'h0, 1, 0, 1, 1, 1, 6'h00};
    vecs[3]  = '{1'b0, 3'd5, 6'h31, 4'h0, 0, 0, 0, 0, 1, 6'h31};
    vecs[4]  = '{1'b0, 3'd3, 6'h14, 4'h0, 0, 0, 1, 0, 0, 6'h15};
    vecs[5]  = '{1'b0, 3'd1, 6'h20, 4'h0, 1, 0, 0, 0, 0, 6'h22};
    vecs[6]  = '{1'b0, 3'd4, 6'h00, 4'h0, 0, 0, 0, 1, 0, 6'h08};
    vecs[7]  = '{1'b0, 3'd5, 6'h00, 4'h0, 0, 0, 0, 0, 1, 6'h10};
    vecs[8]  = '{1'b0, 3'd6, 6'h07, 4'h0, 1, 1, 1, 1, 1, 6'h07};
    vecs[9]  = '{1'b0, 3'd0, 6'h3F, 4'h0, 1, 1, 1, 1, 1, 6'h3F};
    vecs[10] = '{1'b1, 3'd2, 6'h01, 4'hF, 0, 1, 0, 0, 0, 6'h0F};
    vecs[11] = '{1'b0, 3'd4, 6'h30, 4'h0, 1, 1, 1, 0, 1, 6'h30};

    // Reset state and first transition
    idle();
    #1;
    do_reset();
    chk("reset_uaddr", uaddr, 18);
    chk("reset_sp", sp_depth, 0);
    chk("reset_flags", {stack_ovf, stack_unf, seq_err, wdog_trip}, 0);
    j = 6'h05;
    step();
    chk("after_reset_j", uaddr, 6'h05);

    // Branch / dispatch table
    for (int i = 0; i < 12; i++) begin
      idle();
      ird = vecs[i].ird; cond = vecs[i].cond; j = vecs[i].j;
      opcode = vecs[i].opcode; mem_rdy = vecs[i].mem_rdy; ben = vecs[i].ben;
      ir11 = vecs[i].ir11; psr15 = vecs[i].psr15; int_pend = vecs[i].int_pend;
      #1;
      chk($sformatf("vec%0d_next", i), next_uaddr, vecs[i].exp);
      step();
      chk($sformatf("vec%0d_uaddr", i), uaddr, vecs[i].exp);
    end

    // Memory wait self-loop
    go_to(6'h21);
    cond = 1; j = 6'h21; mem_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("memwait%0d", i), uaddr, 6'h21);
    end
    mem_rdy = 1;
    step();
    chk("memwait_done", uaddr, 6'h23);

    // Call and return
    go_to(6'h10);
    call = 1; j = 6'h30;
    step();
    chk("call_uaddr", uaddr, 6'h30);
    chk("call_sp", sp_depth, 1);
    idle(); ret = 1;
    step();
    chk("ret_uaddr", uaddr, 6'h11);
    chk("ret_sp", sp_depth, 0);

    // Return on empty stack
    idle(); ret = 1; j = 6'h2A;
    #1;
    chk("unf_next", next_uaddr, 18);
    step();
    chk("unf_uaddr", uaddr, 18);
    chk("unf_flag", stack_unf, 1);
    chk("unf_no_ovf", stack_ovf, 0);

    // Nested calls to overflow, then unwind LIFO
    do_reset();
    chk("reset_clears_unf", stack_unf, 0);
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1; j = 6'h30 + 6'(i);
      step();
      chk($sformatf("nest%0d_uaddr", i), uaddr, 6'h30 + 6'(i));
      chk($sformatf("nest%0d_ovf", i), stack_ovf, (i == 4) ? 1 : 0);
    end
    chk("nest_sp", sp_depth, 4);
    begin
      logic [5:0] pops [4];
      pops[0] = 6'h33; pops[1] = 6'h32; pops[2] = 6'h31; pops[3] = 6'h13;
      for (int i = 0; i < 4; i++) begin
        idle(); ret = 1;
        step();
        chk($sformatf("unwind%0d", i), uaddr, pops[i]);
      end
    end
    chk("unwind_sp", sp_depth, 0);
    chk("ovf_sticky", stack_ovf, 1);

    // call and ret together: pop only
    do_reset();
    idle(); call = 1; j = 6'h30;
    step();
    idle(); call = 1; ret = 1; j = 6'h3A;
    step();
    chk("both_uaddr", uaddr, 6'h13);
    chk("both_sp", sp_depth, 0);
    chk("both_seq_err", seq_err, 1);
    chk("both_no_unf", stack_unf, 0);

    // Stall freezes everything
    idle(); stall = 1; call = 1; j = 6'h30;
    #1;
    chk("stall_next", next_uaddr, 6'h13);
    step();
    chk("stall_uaddr", uaddr, 6'h13);
    chk("stall_sp", sp_depth, 0);
    idle(); stall = 1; ret = 1;
    step();
    chk("stall_ret_uaddr", uaddr, 6'h13);
    chk("stall_ret_no_unf", stack_unf, 0);
    chk("seq_err_sticky", seq_err, 1);

    // rst overrides other inputs
    idle(); rst = 1; call = 1; j = 6'h2F;
    step();
    chk("rst_over_uaddr", uaddr, 18);
    chk("rst_over_sp", sp_depth, 0);
    chk("rst_over_flags", {stack_ovf, stack_unf, seq_err}, 0);

    // Self-loop: watchdog behaviour
    go_to(6'h21);
    cond = 1; j = 6'h21; mem_rdy = 0;
    saw = 0;
`ifdef USEQ_WATCHDOG_EN
    for (int i = 0; i < 20 && !saw; i++) begin
      step();
      if (wdog_trip) saw = 1;
    end
    chk("wdog_tripped", saw, 1);
    chk("wdog_uaddr", uaddr, 18);
    step();
    chk("wdog_pulse_one", wdog_trip, 0);
`else
    for (int i = 0; i < 20; i++) begin
      step();
      if (wdog_trip) saw = 1;
    end
    chk("wdog_never", saw, 0);
    chk("loop_persists", uaddr, 6'h21);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
